// File: rtl/conv_ctrl_pkg.sv
// Shared types and constants for the conv_ctrl convolution sequencer.
package conv_ctrl_pkg;

    localparam int NUM_FILTERS   = 4;
    localparam int KERNEL        = 3;
    localparam int DIM_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster-order row/col walker over the valid KERNELxKERNEL window origins.
module conv_pos_counter
    import conv_ctrl_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic [DIM_W-1:0] rows,
    input  logic [DIM_W-1:0] cols,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic             last
);

    logic [DIM_W-1:0] row_max;
    logic [DIM_W-1:0] col_max;

    // Only meaningful once rows/cols are known to be >= KERNEL.
    assign row_max = rows - DIM_W'(KERNEL);
    assign col_max = cols - DIM_W'(KERNEL);
    assign last    = (row == row_max) && (col == col_max);

    always_ff @(posedge clk) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv) begin
            if (col == col_max) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_ctrl.sv
// Convolution sequencer for one 4-filter 3x3 computing_core.
// Optional stall counter enabled by defining CONV_CTRL_PERF_EN.
module conv_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIM_W = DIM_W_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DIM_W-1:0]             cfg_rows,
    input  logic [DIM_W-1:0]             cfg_cols,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err,
    output logic                         act_req,
    output logic [DIM_W-1:0]             act_row,
    output logic [DIM_W-1:0]             act_col,
    input  logic                         act_ack,
    output logic                         core_load,
    input  logic [NUM_FILTERS*WIDTH-1:0] core_psum,
    input  logic                         core_psum_vld,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [NUM_FILTERS*WIDTH-1:0] out_data,
    output logic [DIM_W-1:0]             out_row,
    output logic [DIM_W-1:0]             out_col
`ifdef CONV_CTRL_PERF_EN
    ,output logic [31:0]                 perf_stall_cnt
`endif
);

    state_t           state;
    logic [DIM_W-1:0] rows_q;
    logic [DIM_W-1:0] cols_q;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic             pos_clr;
    logic             pos_adv;
    logic             pos_last;
    logic             cfg_ok;

    assign cfg_ok  = (cfg_rows >= DIM_W'(KERNEL)) && (cfg_cols >= DIM_W'(KERNEL));
    assign pos_clr = (state == S_IDLE) && start;
    assign pos_adv = (state == S_OUT) && out_rdy && !pos_last;
    assign act_row = row;
    assign act_col = col;

    conv_pos_counter #(
        .DIM_W (DIM_W)
    ) u_pos (
        .clk  (clk),
        .rst  (rst),
        .clr  (pos_clr),
        .adv  (pos_adv),
        .rows (rows_q),
        .cols (cols_q),
        .row  (row),
        .col  (col),
        .last (pos_last)
    );

    // Pulse outputs default low each cycle; level outputs change on transitions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            rows_q    <= '0;
            cols_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            act_req   <= 1'b0;
            core_load <= 1'b0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            core_load <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rows_q <= cfg_rows;
                        cols_q <= cfg_cols;
                        if (!cfg_ok) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            cfg_err <= 1'b1;
                        end else begin
                            state   <= S_REQ;
                            act_req <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (act_ack) begin
                        act_req   <= 1'b0;
                        core_load <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_psum_vld) begin
                        out_data <= core_psum;
                        out_row  <= row;
                        out_col  <= col;
                        out_vld  <= 1'b1;
                        state    <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        if (pos_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_REQ;
                            act_req <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CONV_CTRL_PERF_EN
    // Stalls are cycles spent waiting on the buffer ack or downstream ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else if (pos_clr) begin
            perf_stall_cnt <= '0;
        end else if (((state == S_REQ && !act_ack) || (state == S_OUT && !out_rdy))
                     && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end
`endif

endmodule
